ft_rx_buffer: RTL and testbench

//  Receive-side byte buffer directly downstream of the FT2232H async-mode controller.
//  - Captures each byte the controller presents with its one-cycle data-valid strobe.
//  - Paces the controller's read request so that no in-flight byte is lost.
//  - Presents stored bytes to the host/uP logic as a valid/ready stream with a registered output.

---
 rtl/ft_rx_buffer_pkg.sv | 15 +
 rtl/ft_sdp_ram.sv | 35 +++
 rtl/ft_rx_buffer.sv | 110 +++++++++++
 tb/tb_ft_rx_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ft_rx_buffer_pkg.sv
// Shared constants for the FT2232H receive path: clock rate, default widths and
// a nanosecond-to-cycle helper used by the async controller and the rx buffer.
package ft_rx_buffer_pkg;

  localparam int unsigned FREQ_MHZ      = 200;
  localparam int unsigned DEF_DATA      = 8;
  localparam int unsigned DEF_ADDR      = 12;
  localparam int unsigned DEF_RD_MARGIN = 4;

  // Round a delay in ns up to whole cycles of the system clock.
  function automatic int unsigned delay2cycles(input int unsigned delay_ns);
    return (delay_ns * FREQ_MHZ + 999) / 1000;
  endfunction

endpackage

// File: rtl/ft_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// clearable output register, shaped so the array maps onto block RAM.
module ft_sdp_ram
  import ft_rx_buffer_pkg::*;
#(
  parameter int unsigned DATA = DEF_DATA,
  parameter int unsigned ADDR = DEF_ADDR
) (
  input  logic            clk,
  input  logic            rd_clr,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_data
);

  localparam int unsigned DEPTH = 2**ADDR;

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_clr)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ft_rx_buffer.sv
// Receive byte buffer behind the FT2232H async controller: captures strobed
// bytes, paces rd_req, and serves a registered valid/ready output stream.
module ft_rx_buffer
  import ft_rx_buffer_pkg::*;
#(
  parameter int unsigned DATA      = DEF_DATA,
  parameter int unsigned ADDR      = DEF_ADDR,
  parameter int unsigned RD_MARGIN = DEF_RD_MARGIN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  output logic            rd_req,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  input  logic            out_ready,
  output logic [ADDR:0]   fill,
  output logic            overflow
);

  localparam int unsigned PTR_W = ADDR + 1;
  localparam int unsigned DEPTH = 2**ADDR;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             rd_req_q, rd_req_d;

  logic flush_c, full_c, empty_c, push_c, pop_c;

  assign flush_c = rst | clr;
  assign full_c  = (fill_q == PTR_W'(DEPTH));
  assign empty_c = (fill_q == '0);
  assign push_c  = in_valid & ~full_c & ~flush_c;
  assign pop_c   = (~out_valid_q | out_ready) & ~empty_c & ~flush_c;

  // Next-state for pointers, output valid, sticky overflow and request pacing.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (in_valid && full_c) overflow_d = 1'b1;

    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Request only while enough room remains for bytes already in flight.
    fill_d   = wr_ptr_d - rd_ptr_d;
    rd_req_d = ((PTR_W'(DEPTH) - fill_d) >= PTR_W'(RD_MARGIN));

    if (flush_c) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      rd_req_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      rd_req_q    <= rd_req_d;
    end
  end

  // The RAM read register doubles as the output data register.
  ft_sdp_ram #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .clk     (clk),
    .rd_clr  (flush_c),
    .wr_en   (push_c),
    .wr_addr (wr_ptr_q[ADDR-1:0]),
    .wr_data (in_data),
    .rd_en   (pop_c),
    .rd_addr (rd_ptr_q[ADDR-1:0]),
    .rd_data (out_data)
  );

  assign rd_req    = rd_req_q;
  assign out_valid = out_valid_q;
  assign fill      = fill_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ft_rx_buffer.sv
// Self-checking bench for ft_rx_buffer (depth 16, margin 4) with a byte
// scoreboard drained by a consumer monitor.
module tb_ft_rx_buffer;

  localparam int unsigned DATA      = 8;
  localparam int unsigned ADDR      = 4;
  localparam int unsigned RD_MARGIN = 4;
  localparam int unsigned DEPTH     = 2**ADDR;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [DATA-1:0] in_data = '0;
  logic            out_ready = 1'b0;
  logic            rd_req;
  logic            out_valid;
  logic [DATA-1:0] out_data;
  logic [ADDR:0]   fill;
  logic            overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pops = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [DATA-1:0] sb_q [$];

  ft_rx_buffer #(
    .DATA      (DATA),
    .ADDR      (ADDR),
    .RD_MARGIN (RD_MARGIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .rd_req    (rd_req),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Consumer side: a byte is taken on the next edge when valid and ready.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_empty", 32'(sb_q.size()), 32'd1);
      else                  check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
      if (pops == 0) first_cyc = cyc;
      last_cyc = cyc;
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA-1:0] d, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    if (accept) sb_q.push_back(d);
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset held three cycles, then release.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rdreq", 32'(rd_req), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_rdreq", 32'(rd_req), 32'd1);

    // Single byte: latency and hold under backpressure.
    push(8'hA5, 1'b1);
    in_valid = 1'b0;
    check("lat_valid_e", 32'(out_valid), 32'd0);
    check("lat_fill_e", 32'(fill), 32'd1);
    tick();
    check("lat_valid_e1", 32'(out_valid), 32'd1);
    check("lat_data_e1", 32'(out_data), 32'hA5);
    check("lat_fill_e1", 32'(fill), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'hA5);
    end
    drain();

    // Fill to capacity with the consumer stalled, then overflow.
    for (int i = 0; i < 16; i++) begin
      int exp_fill;
      push(DATA'(i), 1'b1);
      exp_fill = (i == 0) ? 1 : i;
      check("fill_cnt", 32'(fill), 32'(exp_fill));
      check("fill_rdreq", 32'(rd_req), 32'((DEPTH - exp_fill) >= RD_MARGIN));
    end
    check("fill_head", 32'(out_data), 32'h00);
    check("fill_valid", 32'(out_valid), 32'd1);
    push(8'h10, 1'b1);
    check("full_fill", 32'(fill), 32'd16);
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_rdreq", 32'(rd_req), 32'd0);
    push(8'h11, 1'b0);
    check("drop_fill", 32'(fill), 32'd16);
    check("drop_ovf", 32'(overflow), 32'd1);
    push(8'h12, 1'b0);
    check("drop2_fill", 32'(fill), 32'd16);
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("drained_fill", 32'(fill), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full-rate streaming across two pointer wraps.
    pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(DATA'(i), 1'b1);
      check("stream_fill", 32'(fill <= 1), 32'd1);
    end
    drain();
    check("stream_pops", 32'(pops), 32'd40);
    check("stream_gapless", 32'(last_cyc - first_cyc), 32'd39);

    // Alternating backpressure during a burst.
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 0);
      push(DATA'(8'h80 + i), 1'b1);
    end
    drain();
    check("toggle_pops", 32'(pops), 32'd20);

    // Flush with stored data and a colliding strobe: first rst, then clr.
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push(DATA'(8'h50 + i), 1'b1);
      in_valid = 1'b0;
      check("pre_flush_fill", 32'(fill), 32'd9);
      check("pre_flush_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      if (k == 0) rst = 1'b1;
      else        clr = 1'b1;
      tick();
      rst = 1'b0;
      clr = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_data", 32'(out_data), 32'd0);
      check("flush_fill", 32'(fill), 32'd0);
      check("flush_ovf", 32'(overflow), 32'd0);
      check("flush_rdreq", 32'(rd_req), 32'd0);
      tick();
      check("post_flush_fill", 32'(fill), 32'd0);
      check("post_flush_valid", 32'(out_valid), 32'd0);
      check("post_flush_rdreq", 32'(rd_req), 32'd1);
    end

    // Buffer still operates normally after the flushes.
    push(8'h3C, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
